// File: rtl/mem_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_cmd_pkg
// Description : Shared FSM encoding, response constants and frame-header bit
//               positions for the UART memory command initiator.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_cmd_pkg;

  // Command FSM states, in frame-processing order
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    ISSUE = 3'd3,
    WAIT  = 3'd4,
    SEND  = 3'd5
  } state_t;

  // Single-byte responses
  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] ERR = 8'hEE;

  // Bit positions inside frame byte0 = {rw, mem_type, 5'b0, addr[8]}
  localparam int B0_RW_BIT    = 7;
  localparam int B0_TYPE_BIT  = 6;
  localparam int B0_ADDR8_BIT = 0;

  // Widths of memory read data and of the serialised response word
  localparam int RDATA_W = 42;
  localparam int RESP_W  = 48;

  // Left-pad a memory read word into a full 6-byte response
  function automatic logic [RESP_W-1:0] pad_resp(input logic [RDATA_W-1:0] r);
    return {{(RESP_W-RDATA_W){1'b0}}, r};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_cmd_initiator_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_cmd_initiator_if
// Description : Memory access bus between the command initiator (master) and
//               the instruction/data memories (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_cmd_initiator_if;
  logic        write_mem_req;
  logic        rw_flag;
  logic        target_mem_type;
  logic [8:0]  target_addr;
  logic [31:0] mem_wdata;
  logic        instr_mem_tx_data_ready;
  logic [41:0] instr_mem_rdata;
  logic        data_mem_tx_data_ready;
  logic [41:0] data_mem_rdata;

  modport master (
    output write_mem_req, rw_flag, target_mem_type, target_addr, mem_wdata,
    input  instr_mem_tx_data_ready, instr_mem_rdata,
    input  data_mem_tx_data_ready, data_mem_rdata
  );

  modport slave (
    input  write_mem_req, rw_flag, target_mem_type, target_addr, mem_wdata,
    output instr_mem_tx_data_ready, instr_mem_rdata,
    output data_mem_tx_data_ready, data_mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_cmd_initiator_resp_serializer.sv
`default_nettype none
// ============================================================================
// Module      : resp_serializer
// Description : Loads a response word with a byte count (1 or 6) and shifts
//               it out MSB first over a valid/ready byte handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module resp_serializer
  import mem_cmd_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [RESP_W-1:0] word,
  input  logic [2:0]        count,
  output logic [7:0]        tx_byte,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              done
);

  logic [RESP_W-1:0] r_shift;
  logic [2:0]        r_left;
  logic              w_xfer;

  assign w_xfer   = tx_valid && tx_ready;
  assign tx_valid = (r_left != 3'd0);
  assign tx_byte  = r_shift[RESP_W-1 -: 8];
  assign done     = w_xfer && (r_left == 3'd1);

  // Load a new response or advance one byte per accepted transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_left  <= 3'd0;
    end else if (load) begin
      // A single-byte response lives in the low byte; move it to the output slot
      r_shift <= (count == 3'd1) ? {word[7:0], {(RESP_W-8){1'b0}}} : word;
      r_left  <= count;
    end else if (w_xfer) begin
      r_shift <= {r_shift[RESP_W-9:0], 8'd0};
      r_left  <= r_left - 3'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_cmd_initiator.sv
`default_nettype none
// ============================================================================
// Module      : mem_cmd_initiator
// Description : Parses UART command frames into single memory accesses and
//               returns ACK / ERR / 6-byte read responses over UART.
//               Define MEM_CMD_TIMEOUT_EN to bound the read-response wait to
//               TIMEOUT_CYCLES cycles (ERR is sent on expiry).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_cmd_initiator
  import mem_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
)
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          rx_byte,
  input  logic                rx_valid,
  output logic [7:0]          tx_byte,
  output logic                tx_valid,
  input  logic                tx_ready,
  input  logic                cpu_enable,
  mem_cmd_initiator_if.master mem
);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_rw;
  logic              r_type;
  logic [8:0]        r_addr;
  logic [31:0]       r_wdata;
  logic [1:0]        r_byte_cnt;
  logic              w_req;
  logic              w_load;
  logic [RESP_W-1:0] w_word;
  logic [2:0]        w_count;
  logic              w_done;
  logic              w_ready;
  logic [41:0]       w_rdata;

  // Only the memory addressed by the latched command is listened to
  assign w_ready = r_type ? mem.instr_mem_tx_data_ready : mem.data_mem_tx_data_ready;
  assign w_rdata = r_type ? mem.instr_mem_rdata         : mem.data_mem_rdata;

`ifdef MEM_CMD_TIMEOUT_EN
  localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] r_to_cnt;
  logic       w_timeout;

  // Count consecutive WAIT cycles without a response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= 8'd0;
    end else if (r_state == WAIT && !w_ready) begin
      r_to_cnt <= r_to_cnt + 8'd1;
    end else begin
      r_to_cnt <= 8'd0;
    end
  end

  assign w_timeout = (r_to_cnt == c_TO_LAST);
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state, access strobe and response loading
  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    w_load       = 1'b0;
    w_word       = '0;
    w_count      = 3'd1;
    case (r_state)
      IDLE:  if (rx_valid) w_state_next = ADDR;
      ADDR:  if (rx_valid) w_state_next = r_rw ? DATA : ISSUE;
      DATA:  if (rx_valid && r_byte_cnt == 2'd3) w_state_next = ISSUE;
      ISSUE: begin
        if (cpu_enable) begin
          w_load       = 1'b1;
          w_word       = {{(RESP_W-8){1'b0}}, ERR};
          w_state_next = SEND;
        end else begin
          w_req = 1'b1;
          if (r_rw) begin
            w_load       = 1'b1;
            w_word       = {{(RESP_W-8){1'b0}}, ACK};
            w_state_next = SEND;
          end else begin
            w_state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (w_ready) begin
          w_load       = 1'b1;
          w_word       = pad_resp(w_rdata);
          w_count      = 3'd6;
          w_state_next = SEND;
        end
`ifdef MEM_CMD_TIMEOUT_EN
        else if (w_timeout) begin
          w_load       = 1'b1;
          w_word       = {{(RESP_W-8){1'b0}}, ERR};
          w_state_next = SEND;
        end
`endif
      end
      SEND:    if (w_done) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Latch frame fields as bytes arrive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rw       <= 1'b0;
      r_type     <= 1'b0;
      r_addr     <= 9'd0;
      r_wdata    <= 32'd0;
      r_byte_cnt <= 2'd0;
    end else if (rx_valid) begin
      case (r_state)
        IDLE: begin
          r_rw       <= rx_byte[B0_RW_BIT];
          r_type     <= rx_byte[B0_TYPE_BIT];
          r_addr     <= {rx_byte[B0_ADDR8_BIT], 8'd0};
          r_byte_cnt <= 2'd0;
        end
        ADDR: r_addr[7:0] <= rx_byte;
        DATA: begin
          r_wdata    <= {r_wdata[23:0], rx_byte};
          r_byte_cnt <= r_byte_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign mem.write_mem_req   = w_req;
  assign mem.rw_flag         = r_rw;
  assign mem.target_mem_type = r_type;
  assign mem.target_addr     = r_addr;
  assign mem.mem_wdata       = r_wdata;

  resp_serializer u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .word     (w_word),
    .count    (w_count),
    .tx_byte  (tx_byte),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .done     (w_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_cmd_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_cmd_initiator
// Description : Scoreboard bench for mem_cmd_initiator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_cmd_initiator;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic [7:0] rx_byte    = 8'd0;
  logic       rx_valid   = 1'b0;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready   = 1'b1;
  logic       cpu_enable = 1'b0;

  mem_cmd_initiator_if mem ();

  mem_cmd_initiator #(.TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .tx_byte    (tx_byte),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .cpu_enable (cpu_enable),
    .mem        (mem)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic        typ;
    logic [8:0]  addr;
    logic [31:0] wdata;
  } acc_t;

  int         n_checks   = 0;
  int         n_errors   = 0;
  int         req_pulses = 0;
  logic [7:0] exp_tx[$];
  acc_t       exp_acc[$];
  bit         prev_req   = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_byte  = 8'd0;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected 6-byte read response: {6'b0, r[41:40]} then r[39:0] MSB first
  function automatic void push_resp(input logic [41:0] r);
    exp_tx.push_back({6'b0, r[41:40]});
    for (int i = 4; i >= 0; i--) exp_tx.push_back(r[i*8 +: 8]);
  endfunction

  // Output monitor, sampled mid-cycle
  always @(negedge clk) begin
    acc_t a;
    if (!rst_n) begin
      prev_req   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("tx_hold", {39'd0, tx_valid, tx_byte}, {39'd0, 1'b1, prev_byte});
      if (tx_valid && tx_ready) begin
        check("tx_pending", 48'(exp_tx.size() > 0), 48'd1);
        if (exp_tx.size() > 0) check("tx_byte", 48'(tx_byte), 48'(exp_tx.pop_front()));
      end
      prev_stall = tx_valid && !tx_ready;
      prev_byte  = tx_byte;
      if (mem.write_mem_req) begin
        req_pulses++;
        check("req_single", 48'(prev_req), 48'd0);
        check("req_pending", 48'(exp_acc.size() > 0), 48'd1);
        if (exp_acc.size() > 0) begin
          a = exp_acc.pop_front();
          check("req_rw", 48'(mem.rw_flag), 48'(a.rw));
          check("req_type", 48'(mem.target_mem_type), 48'(a.typ));
          check("req_addr", 48'(mem.target_addr), 48'(a.addr));
          if (a.rw) check("req_wdata", 48'(mem.mem_wdata), 48'(a.wdata));
        end
      end
      prev_req = mem.write_mem_req;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_req();
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = mem.write_mem_req;
    end
    check("req_seen", 48'(seen), 48'd1);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_tx.size() == 0 && !tx_valid) break;
    end
    check({tag, "_drain"}, 48'(exp_tx.size()), 48'd0);
    check({tag, "_idle_valid"}, 48'(tx_valid), 48'd0);
  endtask

  task automatic mem_pulse(input bit instr, input logic [41:0] r);
    @(posedge clk); #1;
    if (instr) begin
      mem.instr_mem_rdata = r; mem.instr_mem_tx_data_ready = 1'b1;
    end else begin
      mem.data_mem_rdata = r;  mem.data_mem_tx_data_ready = 1'b1;
    end
    @(posedge clk); #1;
    mem.instr_mem_tx_data_ready = 1'b0;
    mem.data_mem_tx_data_ready  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   48'(mem.write_mem_req),   48'd0);
    check({tag, "_rw"},    48'(mem.rw_flag),         48'd0);
    check({tag, "_type"},  48'(mem.target_mem_type), 48'd0);
    check({tag, "_addr"},  48'(mem.target_addr),     48'd0);
    check({tag, "_wdata"}, 48'(mem.mem_wdata),       48'd0);
    check({tag, "_txv"},   48'(tx_valid),            48'd0);
    check({tag, "_txb"},   48'(tx_byte),             48'd0);
  endtask

  initial begin
    int base;
    int lat;
    mem.instr_mem_tx_data_ready = 1'b0;
    mem.instr_mem_rdata         = '0;
    mem.data_mem_tx_data_ready  = 1'b0;
    mem.data_mem_rdata          = '0;

    repeat (3) @(posedge clk);
    #1 check_reset_outputs("rst");
    rst_n = 1'b1;

    // Write to instruction memory
    exp_acc.push_back('{1'b1, 1'b1, 9'd5, 32'hDEADBEEF});
    exp_tx.push_back(8'hA5);
    base = req_pulses;
    foreach (exp_tx[i]) ;
    send_byte(8'hC0); send_byte(8'h05);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    wait_drain("wr");
    check("wr_pulses", 48'(req_pulses - base), 48'd1);

    // Read from data memory
    exp_acc.push_back('{1'b0, 1'b0, 9'h110, 32'd0});
    push_resp({1'b1, 9'h110, 32'h12345678});
    send_byte(8'h01); send_byte(8'h10);
    wait_req();
    mem_pulse(1'b0, {1'b1, 9'h110, 32'h12345678});
    wait_drain("rd");

    // CPU running: access refused
    cpu_enable = 1'b1;
    base = req_pulses;
    exp_tx.push_back(8'hEE);
    send_byte(8'h00); send_byte(8'h22);
    wait_drain("busy");
    check("busy_pulses", 48'(req_pulses - base), 48'd0);
    cpu_enable = 1'b0;

    // Wrong-memory ready ignored, backpressure, bytes dropped during SEND
    tx_ready = 1'b0;
    exp_acc.push_back('{1'b0, 1'b0, 9'h1FF, 32'd0});
    push_resp({1'b0, 9'h1FF, 32'hCAFE0123});
    send_byte(8'h01); send_byte(8'hFF);
    wait_req();
    mem_pulse(1'b1, {1'b1, 9'h0AA, 32'h55555555});
    mem_pulse(1'b0, {1'b0, 9'h1FF, 32'hCAFE0123});
    send_byte(8'hC0); send_byte(8'h05);
    repeat (6) @(posedge clk);
    #1 tx_ready = 1'b1;
    wait_drain("bp");

    // Follow-up write must parse cleanly after the dropped bytes
    exp_acc.push_back('{1'b1, 1'b0, 9'h033, 32'h01020304});
    exp_tx.push_back(8'hA5);
    send_byte(8'h80); send_byte(8'h33);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    wait_drain("wr2");

    // Reset in the middle of a write frame
    send_byte(8'hC0); send_byte(8'h05); send_byte(8'hDE);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_acc.push_back('{1'b0, 1'b1, 9'h123, 32'd0});
    push_resp({1'b1, 9'h123, 32'h89ABCDEF});
    send_byte(8'h41); send_byte(8'h23);
    wait_req();
    mem_pulse(1'b0, {1'b1, 9'h0FF, 32'h11111111});
    mem_pulse(1'b1, {1'b1, 9'h123, 32'h89ABCDEF});
    wait_drain("postrst");

`ifdef MEM_CMD_TIMEOUT_EN
    // No response from the addressed memory: ERR after 8 WAIT cycles
    exp_acc.push_back('{1'b0, 1'b0, 9'h044, 32'd0});
    exp_tx.push_back(8'hEE);
    send_byte(8'h00); send_byte(8'h44);
    wait_req();
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      mem.instr_mem_tx_data_ready = (i == 3);
      if (tx_valid) begin
        lat = i;
        break;
      end
    end
    mem.instr_mem_tx_data_ready = 1'b0;
    check("to_latency", 48'(lat), 48'd9);
    wait_drain("to");
`else
    lat = 0;
`endif

    check("acc_left", 48'(exp_acc.size()), 48'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
